modaddsub_pipe: RTL
===================

MODADDSUB_PIPE -- requirements
Module: modaddsub_pipe

Interface
REQ-001 SHALL have parameter LOGQ, default 64: operand and modulus width in bits.
REQ-002 SHALL have parameter LOGQH, default 47: width of the qH modulus-high field, with LOGQH < LOGQ.
REQ-003 SHALL have parameter LANES, default 4: number of independent lanes, which SHALL be at least 1.
REQ-004 SHALL have parameter TAGW, default 8: sideband tag width, carried through unchanged.
REQ-005 SHALL have parameters FF_IN, FF_OP, FF_OUT, each default 1 with legal values 0 or 1: register-stage enables.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: an input beat is present.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts the beat in this cycle.
REQ-010 SHALL have port in_mode, input, LANES bits: per lane, 0 = add and 1 = sub.
REQ-011 SHALL have ports in_a and in_b, inputs, LANES*LOGQ bits each: operands, lane i at bits [i*LOGQ +: LOGQ].
REQ-012 SHALL have port in_tag, input, TAGW bits: sideband tag.
REQ-013 SHALL have port qH, input, LOGQH bits: modulus high field, shared by all lanes and held static while any beat is in flight.
REQ-014 SHALL have port out_valid, output, 1 bit: a result beat is present.
REQ-015 SHALL have port out_ready, input, 1 bit: the downstream accepts the result beat.
REQ-016 SHALL have port out_data, output, LANES*LOGQ bits: results, packed like in_a.
REQ-017 SHALL have port out_tag, output, TAGW bits: the tag of the result beat.
REQ-018 SHALL have port out_err, output, LANES bits: per-lane operand-range error flag.

Function
REQ-019 SHALL use modulus q = qH*2^(LOGQ-LOGQH) + 1, LOGQ bits wide, formed as qH, then (LOGQ-LOGQH-1) zero bits, then a 1 in the LSB.
REQ-020 SHALL compute add lanes as R = A+B at LOGQ+1 bits and T = R-q, with result T when T >= 0 and R otherwise.
REQ-021 SHALL compute sub lanes as R = A-B at LOGQ+1 bits, with result R when R[LOGQ] = 0 and R+q truncated to LOGQ bits otherwise.
REQ-022 SHALL produce out_data in [0, q) for every lane whose inputs A and B are both below q.
REQ-023 SHALL have latency LAT = FF_IN + FF_OP + FF_OUT cycles from accept to out_valid when not stalled.
REQ-024 SHALL, when LAT = 0, be fully combinational: out_valid = in_valid and in_ready = out_ready.
REQ-025 SHALL accept a beat exactly when in_valid && in_ready, and SHALL deliver a beat exactly when out_valid && out_ready.
REQ-026 SHALL use a global advance enable en = !out_valid || out_ready, advancing all stages together and driving in_ready = en.
REQ-027 SHALL, while out_valid=1 and out_ready=0, hold out_data, out_tag and out_err stable, keep in_ready=0, and lose or duplicate no beat.
REQ-028 SHALL carry a valid bit per stage so that bubbles propagate and a beat is presented exactly once.
REQ-029 SHALL sustain full throughput of one beat per cycle while out_ready=1.
REQ-030 SHALL carry in_tag, in_mode and the lane-error bits in the same stage as their data.
REQ-031 SHALL handle every lane independently, so mixed add and sub lanes in one beat are legal.

Reset
REQ-032 SHALL, on a clk edge with rst=1, clear all stage valid bits and set every pipeline data, tag and err register to 0.
REQ-033 SHALL, in the cycle after reset, present out_valid=0, out_data=0, out_tag=0, out_err=0 and in_ready=1.
REQ-034 SHALL, on reset mid-operation, discard all in-flight beats so that none appears on the output afterwards.
REQ-035 SHALL ignore any beat presented in the same cycle as rst=1.

Configuration
REQ-036 SHALL provide macro MODADDSUB_PIPE_RANGE_CHECK_EN.
REQ-037 SHALL, with the macro defined, set out_err[i]=1 when lane i had A >= q or B >= q at accept, and still deliver that lane's data, which is then unspecified.
REQ-038 SHALL, without the macro, tie out_err to 0 and synthesise no comparators, with the port still present.

Verification
REQ-039 SHALL cover: LOGQ=8, LOGQH=4, qH=12 (q=193), lane add 150+100 -> out 57 after 3 cycles, out_err=0.
REQ-040 SHALL cover: same q, lane sub 10-20 -> out 183; boundary add 192+192 -> 191; sub 0-0 -> 0, with all four in one beat over LANES=4.
REQ-041 SHALL cover: back-to-back stream of 20 beats with tags 0..19 and out_ready low in cycles 5-9 -> all 20 out in order, with data stable while stalled and in_ready=0 during the stall.
REQ-042 SHALL cover: rst pulsed for one cycle with 3 beats in flight -> no out_valid on the following cycle and no stale beats afterwards.
REQ-043 SHALL cover: with the macro defined, A=193 in lane 2 -> out_err=4'b0100; without the macro -> out_err=0.
REQ-044 SHALL cover: FF_IN=FF_OP=FF_OUT=0 -> add 150+100 gives 57 in the same cycle, with in_ready following out_ready.

Source files
------------

// File: rtl/modaddsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : modaddsub_pipe_if
// Brief    : Valid/ready beat bus for the modular add/sub pipeline.
// Revision : 1.0
// ============================================================================
interface modaddsub_pipe_if #(
  parameter int LOGQ  = 64,
  parameter int LANES = 4,
  parameter int TAGW  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_mode;
  logic [LANES*LOGQ-1:0] in_a;
  logic [LANES*LOGQ-1:0] in_b;
  logic [TAGW-1:0]       in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*LOGQ-1:0] out_data;
  logic [TAGW-1:0]       out_tag;
  logic [LANES-1:0]      out_err;

  modport master (
    output in_valid, in_mode, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface
`default_nettype wire

// File: rtl/modaddsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : modaddsub_pipe
// Brief    : Multi-lane pipelined modular add/sub, q = qH*2^(LOGQ-LOGQH)+1.
//            Optional range check: define MODADDSUB_PIPE_RANGE_CHECK_EN.
// Revision : 1.0
// ============================================================================
module modaddsub_pipe #(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter int LANES  = 4,
  parameter int TAGW   = 8,
  parameter int FF_IN  = 1,
  parameter int FF_OP  = 1,
  parameter int FF_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LOGQH-1:0] qH,
  modaddsub_pipe_if.slave  bus
);
  localparam int LAT = FF_IN + FF_OP + FF_OUT;
  localparam int SH  = LOGQ - LOGQH;
  localparam int W   = LANES * LOGQ;
  localparam int RW  = LANES * (LOGQ + 1);

  logic [LOGQ-1:0] q;
  logic            en;

  logic             s0_v;
  logic [LANES-1:0] s0_mode;
  logic [W-1:0]     s0_a;
  logic [W-1:0]     s0_b;
  logic [TAGW-1:0]  s0_tag;

  logic [RW-1:0]    p1_r;
  logic [LANES-1:0] p1_err;

  logic             s1_v;
  logic [LANES-1:0] s1_mode;
  logic [RW-1:0]    s1_r;
  logic [TAGW-1:0]  s1_tag;
  logic [LANES-1:0] s1_err;

  logic [W-1:0]     p2_data;

  logic             s2_v;
  logic [W-1:0]     s2_data;
  logic [TAGW-1:0]  s2_tag;
  logic [LANES-1:0] s2_err;

  // SH >= 1 always, so the low bit lands in the zero-filled tail.
  assign q  = {qH, {SH{1'b0}}} | LOGQ'(1);
  assign en = !s2_v || bus.out_ready;

  assign bus.in_ready  = (LAT == 0) ? bus.out_ready : en;
  assign bus.out_valid = s2_v;
  assign bus.out_data  = s2_data;
  assign bus.out_tag   = s2_tag;
  assign bus.out_err   = s2_err;

  if (FF_IN != 0) begin : g_ff_in
    always_ff @(posedge clk) begin
      if (rst) begin
        s0_v    <= 1'b0;
        s0_mode <= '0;
        s0_a    <= '0;
        s0_b    <= '0;
        s0_tag  <= '0;
      end else if (en) begin
        s0_v    <= bus.in_valid;
        s0_mode <= bus.in_mode;
        s0_a    <= bus.in_a;
        s0_b    <= bus.in_b;
        s0_tag  <= bus.in_tag;
      end
    end
  end else begin : g_no_ff_in
    always_comb begin
      s0_v    = bus.in_valid;
      s0_mode = bus.in_mode;
      s0_a    = bus.in_a;
      s0_b    = bus.in_b;
      s0_tag  = bus.in_tag;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_p1
    logic [LOGQ-1:0] a;
    logic [LOGQ-1:0] b;
    assign a = s0_a[i*LOGQ +: LOGQ];
    assign b = s0_b[i*LOGQ +: LOGQ];
    assign p1_r[i*(LOGQ+1) +: LOGQ+1] = s0_mode[i] ? ({1'b0, a} - {1'b0, b})
                                                   : ({1'b0, a} + {1'b0, b});
`ifdef MODADDSUB_PIPE_RANGE_CHECK_EN
    assign p1_err[i] = (a >= q) || (b >= q);
`else
    assign p1_err[i] = 1'b0;
`endif
  end

  if (FF_OP != 0) begin : g_ff_op
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v    <= 1'b0;
        s1_mode <= '0;
        s1_r    <= '0;
        s1_tag  <= '0;
        s1_err  <= '0;
      end else if (en) begin
        s1_v    <= s0_v;
        s1_mode <= s0_mode;
        s1_r    <= p1_r;
        s1_tag  <= s0_tag;
        s1_err  <= p1_err;
      end
    end
  end else begin : g_no_ff_op
    always_comb begin
      s1_v    = s0_v;
      s1_mode = s0_mode;
      s1_r    = p1_r;
      s1_tag  = s0_tag;
      s1_err  = p1_err;
    end
  end

  // Add: subtract q once if the raw sum reached q. Sub: add q back on borrow.
  for (genvar i = 0; i < LANES; i++) begin : g_p2
    logic [LOGQ:0] r;
    assign r = s1_r[i*(LOGQ+1) +: LOGQ+1];
    assign p2_data[i*LOGQ +: LOGQ] =
      s1_mode[i] ? (r[LOGQ] ? (r[LOGQ-1:0] + q) : r[LOGQ-1:0])
                 : ((r >= {1'b0, q}) ? (r[LOGQ-1:0] - q) : r[LOGQ-1:0]);
  end

  if (FF_OUT != 0) begin : g_ff_out
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_v    <= 1'b0;
        s2_data <= '0;
        s2_tag  <= '0;
        s2_err  <= '0;
      end else if (en) begin
        s2_v    <= s1_v;
        s2_data <= p2_data;
        s2_tag  <= s1_tag;
        s2_err  <= s1_err;
      end
    end
  end else begin : g_no_ff_out
    always_comb begin
      s2_v    = s1_v;
      s2_data = p2_data;
      s2_tag  = s1_tag;
      s2_err  = s1_err;
    end
  end
endmodule
`default_nettype wire
